// File: rtl/video_grayscale_stage_if.sv
// Display-mode type shared with the display-mode bridge, and the video timing/pixel
// bundle used on both sides of the grayscale stage.
package pocket;
  typedef enum logic [1:0] {
    DmNormal = 2'd0,
    DmLcd    = 2'd1,
    DmCrt    = 2'd2,
    DmCustom = 2'd3
  } display_mode_e;
endpackage

interface video_grayscale_stage_if;
  logic        vs;
  logic        hs;
  logic        de;
  logic        skip;
  logic [23:0] rgb;

  modport master (output vs, hs, de, skip, rgb);
  modport slave  (input  vs, hs, de, skip, rgb);
endinterface

// File: rtl/video_grayscale_stage.sv
// Three-stage RGB-to-luma pipeline with a frame-latched grayscale enable; timing and
// control words pass through with the same fixed latency.
module video_grayscale_stage #(
  parameter int unsigned LATENCY = 3,
  parameter bit          ROUND   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  pocket::display_mode_e   display_mode,
  input  logic                    grayscale,
  video_grayscale_stage_if.slave  vid_in,
  video_grayscale_stage_if.master vid_out,
  output pocket::display_mode_e   frame_display_mode,
  output logic                    frame_grayscale,
  output logic                    mode_pending
);

  if (LATENCY != 3) begin : g_latency_check
    $error("video_grayscale_stage: only LATENCY=3 is supported");
  end

  logic                  prev_vs_q;
  logic                  frame_gray_q;
  pocket::display_mode_e frame_dm_q;
  logic                  frame_start;
  logic                  gray_eff;

  // Timing vectors are packed as {vs, hs, de, skip}.
  logic [3:0]  s1_tim_q, s2_tim_q, out_tim_q;
  logic [23:0] s1_rgb_q, s2_rgb_q, out_rgb_q;
  logic        s1_gray_q, s2_gray_q;
  logic [15:0] pr_d, pg_d, pb_d, sum_d;
  logic [15:0] pr_q, pg_q, pb_q, sum_q;
  logic [7:0]  luma;
  logic [23:0] out_rgb_d;

  always_comb begin
    frame_start = vid_in.vs & ~prev_vs_q;
    // A mode change coinciding with the vs rise already applies to this pixel.
    gray_eff    = frame_start ? grayscale : frame_gray_q;
    pr_d        = 16'd77  * {8'd0, vid_in.rgb[23:16]};
    pg_d        = 16'd150 * {8'd0, vid_in.rgb[15:8]};
    pb_d        = 16'd29  * {8'd0, vid_in.rgb[7:0]};
    sum_d       = pr_q + pg_q + pb_q + (ROUND ? 16'd128 : 16'd0);
    luma        = 8'(sum_q >> 8);
    out_rgb_d   = (s2_tim_q[1] && s2_gray_q) ? {3{luma}} : s2_rgb_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_vs_q    <= 1'b0;
      frame_gray_q <= 1'b0;
      frame_dm_q   <= pocket::DmNormal;
      s1_tim_q     <= '0;
      s1_rgb_q     <= '0;
      s1_gray_q    <= 1'b0;
      pr_q         <= '0;
      pg_q         <= '0;
      pb_q         <= '0;
      s2_tim_q     <= '0;
      s2_rgb_q     <= '0;
      s2_gray_q    <= 1'b0;
      sum_q        <= '0;
      out_tim_q    <= '0;
      out_rgb_q    <= '0;
    end else begin
      prev_vs_q <= vid_in.vs;
      if (frame_start) begin
        frame_gray_q <= grayscale;
        frame_dm_q   <= display_mode;
      end
      s1_tim_q  <= {vid_in.vs, vid_in.hs, vid_in.de, vid_in.skip};
      s1_rgb_q  <= vid_in.rgb;
      s1_gray_q <= gray_eff;
      pr_q      <= pr_d;
      pg_q      <= pg_d;
      pb_q      <= pb_d;
      s2_tim_q  <= s1_tim_q;
      s2_rgb_q  <= s1_rgb_q;
      s2_gray_q <= s1_gray_q;
      sum_q     <= sum_d;
      out_tim_q <= s2_tim_q;
      out_rgb_q <= out_rgb_d;
    end
  end

  assign vid_out.vs   = out_tim_q[3];
  assign vid_out.hs   = out_tim_q[2];
  assign vid_out.de   = out_tim_q[1];
  assign vid_out.skip = out_tim_q[0];
  assign vid_out.rgb  = out_rgb_q;

  assign frame_display_mode = frame_dm_q;
  assign frame_grayscale    = frame_gray_q;
  assign mode_pending       = (grayscale != frame_gray_q) || (display_mode != frame_dm_q);

endmodule

// File: tb/tb_video_grayscale_stage.sv
// Directed scenarios with literal expectations, then random video checked every cycle
// against a frame-level reference model.
module tb_video_grayscale_stage;
  import pocket::*;

  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        de;
    logic        skip;
    logic [23:0] rgb;
  } vid_t;

  logic          clk;
  logic          reset;
  display_mode_e display_mode;
  logic          grayscale;
  display_mode_e frame_display_mode;
  logic          frame_grayscale;
  logic          mode_pending;

  video_grayscale_stage_if vi ();
  video_grayscale_stage_if vo ();

  video_grayscale_stage dut (
    .clk                (clk),
    .reset              (reset),
    .display_mode       (display_mode),
    .grayscale          (grayscale),
    .vid_in             (vi),
    .vid_out            (vo),
    .frame_display_mode (frame_display_mode),
    .frame_grayscale    (frame_grayscale),
    .mode_pending       (mode_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] luma(input logic [23:0] p);
    int y;
    y = (77 * p[23:16] + 150 * p[15:8] + 29 * p[7:0] + 128) / 256;
    return y[7:0];
  endfunction

  // Reference model: frame-latched mode plus a queue of per-edge expected outputs.
  logic          m_prev_vs = 1'b0;
  logic          m_fg = 1'b0;
  display_mode_e m_fdm = DmNormal;
  int            since_rst = 0;
  logic          model_en = 1'b0;
  vid_t          pipe[$];
  vid_t          ent;

  always @(posedge clk) begin
    if (reset) begin
      m_prev_vs = 1'b0;
      m_fg      = 1'b0;
      m_fdm     = DmNormal;
      since_rst = 0;
      model_en  = 1'b1;
      ent       = '0;
    end else begin
      if (vi.vs && !m_prev_vs) begin
        m_fg  = grayscale;
        m_fdm = display_mode;
      end
      m_prev_vs = vi.vs;
      ent = '{vs: vi.vs, hs: vi.hs, de: vi.de, skip: vi.skip, rgb: vi.rgb};
      if (vi.de && m_fg) ent.rgb = {3{luma(vi.rgb)}};
      if (since_rst < 1000) since_rst++;
    end
    pipe.push_back(ent);
    if (pipe.size() > 3) void'(pipe.pop_front());
  end

  always @(negedge clk) begin
    vid_t exp_v;
    if (model_en) begin
      exp_v = (since_rst <= 2 || pipe.size() < 3) ? '0 : pipe[0];
      chk("out_timing", {28'd0, vo.vs, vo.hs, vo.de, vo.skip},
          {28'd0, exp_v.vs, exp_v.hs, exp_v.de, exp_v.skip});
      chk("out_rgb", {8'd0, vo.rgb}, {8'd0, exp_v.rgb});
      chk("frame_grayscale", {31'd0, frame_grayscale}, {31'd0, m_fg});
      chk("frame_display_mode", {30'd0, frame_display_mode}, {30'd0, m_fdm});
      chk("mode_pending", {31'd0, mode_pending},
          {31'd0, (grayscale != m_fg) || (display_mode != m_fdm)});
    end
  end

  logic          cur_g = 1'b0;
  display_mode_e cur_dm = DmNormal;

  task automatic cyc(input logic rst, input logic vs, input logic hs, input logic de,
                     input logic [23:0] rgb);
    reset        = rst;
    vi.vs        = vs;
    vi.hs        = hs;
    vi.de        = de;
    vi.skip      = 1'b0;
    vi.rgb       = rgb;
    grayscale    = cur_g;
    display_mode = cur_dm;
    @(posedge clk);
    #1;
  endtask

  task automatic idle2(input logic vs);
    cyc(1'b0, vs, 1'b0, 1'b0, 24'h0);
    cyc(1'b0, vs, 1'b0, 1'b0, 24'h0);
  endtask

  initial begin
    // Reset, then idle.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    chk("reset_rgb", {8'd0, vo.rgb}, 32'h0);
    chk("reset_de", {31'd0, vo.de}, 32'h0);
    chk("reset_fg", {31'd0, frame_grayscale}, 32'h0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);

    // White stays white once grayscale is latched at the vs rise.
    cur_g = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 24'hFFFFFF);
    chk("white_fg", {31'd0, frame_grayscale}, 32'h1);
    idle2(1'b1);
    chk("white_rgb", {8'd0, vo.rgb}, 32'h00FFFFFF);
    chk("white_de", {31'd0, vo.de}, 32'h1);

    // Primary colours.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 24'hFF0000);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 24'h00FF00);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 24'h0000FF);
    chk("red_luma", {8'd0, vo.rgb}, 32'h004D4D4D);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    chk("green_luma", {8'd0, vo.rgb}, 32'h00959595);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    chk("blue_luma", {8'd0, vo.rgb}, 32'h001D1D1D);

    // Control word passes unmodified.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 24'hABCDEF);
    idle2(1'b1);
    chk("ctrl_rgb", {8'd0, vo.rgb}, 32'h00ABCDEF);
    chk("ctrl_hs", {31'd0, vo.hs}, 32'h1);

    // Mid-frame grayscale request waits for the next frame.
    cur_g = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    chk("mid_fg_off", {31'd0, frame_grayscale}, 32'h0);
    cur_g = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 24'h123456);
    chk("mid_pending", {31'd0, mode_pending}, 32'h1);
    idle2(1'b1);
    chk("mid_rgb", {8'd0, vo.rgb}, 32'h00123456);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 24'h123456);
    chk("next_pending", {31'd0, mode_pending}, 32'h0);
    chk("next_fg", {31'd0, frame_grayscale}, 32'h1);
    idle2(1'b1);
    chk("next_rgb", {8'd0, vo.rgb}, 32'h002E2E2E);

    // Mode change coinciding with the vs rise.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    cur_g  = 1'b0;
    cur_dm = DmCrt;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    chk("edge_fg", {31'd0, frame_grayscale}, 32'h0);
    chk("edge_fdm", {30'd0, frame_display_mode}, {30'd0, DmCrt});

    // One-cycle reset mid-frame with grayscale active.
    cur_g = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 24'h123456);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 24'h123456);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 24'h123456);
    chk("rst_rgb", {8'd0, vo.rgb}, 32'h0);
    chk("rst_fg", {31'd0, frame_grayscale}, 32'h0);
    chk("rst_fdm", {30'd0, frame_display_mode}, {30'd0, DmNormal});
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'h123456);
    idle2(1'b0);
    chk("post_rst_rgb", {8'd0, vo.rgb}, 32'h00123456);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 24'h123456);
    chk("post_rst_fg", {31'd0, frame_grayscale}, 32'h1);
    idle2(1'b1);
    chk("post_rst_gray", {8'd0, vo.rgb}, 32'h002E2E2E);

    // Random traffic, checked by the per-cycle compare process.
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) vi.vs = ~vi.vs;
      vi.hs        = ($urandom_range(0, 7) == 0);
      vi.de        = $urandom_range(0, 1) == 1;
      vi.skip      = ($urandom_range(0, 15) == 0);
      vi.rgb       = 24'($urandom);
      if ($urandom_range(0, 49) == 0) cur_g = ~cur_g;
      if ($urandom_range(0, 59) == 0) cur_dm = display_mode_e'($urandom_range(0, 3));
      grayscale    = cur_g;
      display_mode = cur_dm;
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
